// File: rtl/projectile_pool_pkg.sv
// Shared screen constants, slot state encodings and a population-count helper
// for the projectile pool.
package projectile_pool_pkg;

  // Visible screen size and default on-screen vertical bounds.
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int DEF_Y_MIN = 0;
  localparam int DEF_Y_MAX = SCREEN_H - 1;

  // Per-slot state: the state bit doubles as the slot's active flag.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_FLYING = 1'b1;

  // Number of set bits in a mask of up to 16 slots.
  function automatic logic [4:0] count_ones(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/projectile_pool_slot_alloc.sv
// Lowest-set-bit finder over the free-slot mask: returns the index of the
// lowest free slot and whether any slot is free at all.
module slot_alloc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     free,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/projectile_pool.sv
// N-slot projectile manager: allocates shots on fire requests, steps every
// live shot once per video frame, retires shots on hit or off-screen exit.
module projectile_pool
  import projectile_pool_pkg::*;
#(
  parameter int SLOTS    = 4,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int SPEED    = 4,
  parameter int DIR_UP   = 1,
  parameter int Y_MIN    = DEF_Y_MIN,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int COOLDOWN = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         frame,
  input  logic                         fire,
  input  logic [X_W-1:0]               fire_x,
  input  logic [Y_W-1:0]               fire_y,
  input  logic [SLOTS-1:0]             hit,
  output logic [SLOTS-1:0]             active,
  output logic [SLOTS*X_W-1:0]         proj_x,
  output logic [SLOTS*Y_W-1:0]         proj_y,
  output logic                         fire_ack,
  output logic                         fire_drop,
  output logic [$clog2(SLOTS+1)-1:0]   live_cnt
);

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [SLOTS-1:0] state;
  logic [IDX_W-1:0] free_idx;
  logic             free_valid;
  logic [CD_W-1:0]  cooldown;
  logic             accept;

  // Allocation only ever looks at registered state, so a slot freed by a hit
  // this cycle is not visible as free until the next one.
  slot_alloc #(
    .N     (SLOTS),
    .IDX_W (IDX_W)
  ) u_alloc (
    .free  (~state),
    .idx   (free_idx),
    .valid (free_valid)
  );

  assign accept   = fire && (cooldown == '0) && free_valid;
  assign active   = state;
  assign live_cnt = CNT_W'(count_ones(16'(state)));

  // Per-slot state and coordinate registers.
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic [0:0]     slot_state;
    logic [X_W-1:0] x_r;
    logic [Y_W-1:0] y_r;
    logic [Y_W:0]   y_next;
    logic           below;
    logic           off_screen;
    logic           load;

    // One extra bit catches underflow (up) and overflow (down) of the step.
    if (DIR_UP != 0) begin : g_up
      assign y_next = {1'b0, y_r} - (Y_W + 1)'(SPEED);
    end else begin : g_down
      assign y_next = {1'b0, y_r} + (Y_W + 1)'(SPEED);
    end

    // A zero top bound can only be crossed by wrapping, which the extra bit covers.
    if (Y_MIN > 0) begin : g_min
      assign below = y_next < (Y_W + 1)'(Y_MIN);
    end else begin : g_no_min
      assign below = 1'b0;
    end

    assign off_screen = ((DIR_UP != 0) && y_next[Y_W]) || below ||
                        (y_next > (Y_W + 1)'(Y_MAX));
    assign load       = accept && (free_idx == IDX_W'(i));

    // Load on allocation; otherwise hit beats frame step; coordinates hold when idle.
    always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
        slot_state <= ST_IDLE;
        x_r        <= '0;
        y_r        <= '0;
      end else if (clear) begin
        slot_state <= ST_IDLE;
        x_r        <= '0;
        y_r        <= '0;
      end else if (load) begin
        slot_state <= ST_FLYING;
        x_r        <= fire_x;
        y_r        <= fire_y;
      end else if (slot_state == ST_FLYING) begin
        if (hit[i]) begin
          slot_state <= ST_IDLE;
        end else if (frame) begin
          if (off_screen) slot_state <= ST_IDLE;
          else            y_r        <= y_next[Y_W-1:0];
        end
      end
    end

    assign state[i]               = (slot_state == ST_FLYING);
    assign proj_x[i*X_W +: X_W]   = x_r;
    assign proj_y[i*Y_W +: Y_W]   = y_r;
  end

  // Fire cooldown: reloads on an accepted shot, counts frames down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cooldown <= '0;
    end else if (clear) begin
      cooldown <= '0;
    end else if (accept) begin
      cooldown <= CD_W'(COOLDOWN);
    end else if (frame && (cooldown != '0)) begin
      cooldown <= cooldown - 1'b1;
    end
  end

  // Registered one-cycle accept / refuse responses to a fire request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_ack  <= 1'b0;
      fire_drop <= 1'b0;
    end else if (clear) begin
      fire_ack  <= 1'b0;
      fire_drop <= 1'b0;
    end else begin
      fire_ack  <= accept;
      fire_drop <= fire && !accept;
    end
  end

endmodule

// File: tb/tb_projectile_pool.sv
// Self-checking bench for projectile_pool: two instances (player shots going
// up with no cooldown, bombs going down with a 2-frame cooldown) driven in
// lock-step; a behavioural model queues expected outputs per cycle.
module tb_projectile_pool;

  localparam int SLOTS = 4;
  localparam int XW    = 10;
  localparam int YW    = 10;
  localparam int SPEED = 4;
  localparam int Y_MIN = 0;
  localparam int Y_MAX = 479;

  typedef struct {
    logic               ack;
    logic               drop;
    logic [SLOTS-1:0]   act;
    logic [SLOTS*XW-1:0] px;
    logic [SLOTS*YW-1:0] py;
    logic [2:0]         cnt;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst   [2];
  logic                clear [2];
  logic                frame [2];
  logic                fire  [2];
  logic [XW-1:0]       fx    [2];
  logic [YW-1:0]       fy    [2];
  logic [SLOTS-1:0]    hit   [2];
  logic [SLOTS-1:0]    act   [2];
  logic [SLOTS*XW-1:0] px    [2];
  logic [SLOTS*YW-1:0] py    [2];
  logic                ack   [2];
  logic                drop  [2];
  logic [2:0]          cnt   [2];

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  int m_act [2][SLOTS];
  int m_x   [2][SLOTS];
  int m_y   [2][SLOTS];
  int m_cd  [2];
  int dir_up[2] = '{1, 0};
  int cd_len[2] = '{0, 2};

  projectile_pool #(
    .SLOTS(SLOTS), .X_W(XW), .Y_W(YW), .SPEED(SPEED), .DIR_UP(1),
    .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .COOLDOWN(0)
  ) u_up (
    .clk(clk), .rst(rst[0]), .clear(clear[0]), .frame(frame[0]), .fire(fire[0]),
    .fire_x(fx[0]), .fire_y(fy[0]), .hit(hit[0]), .active(act[0]),
    .proj_x(px[0]), .proj_y(py[0]), .fire_ack(ack[0]), .fire_drop(drop[0]),
    .live_cnt(cnt[0])
  );

  projectile_pool #(
    .SLOTS(SLOTS), .X_W(XW), .Y_W(YW), .SPEED(SPEED), .DIR_UP(0),
    .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .COOLDOWN(2)
  ) u_down (
    .clk(clk), .rst(rst[1]), .clear(clear[1]), .frame(frame[1]), .fire(fire[1]),
    .fire_x(fx[1]), .fire_y(fy[1]), .hit(hit[1]), .active(act[1]),
    .proj_x(px[1]), .proj_y(py[1]), .fire_ack(ack[1]), .fire_drop(drop[1]),
    .live_cnt(cnt[1])
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model of one pool for the cycle about to be clocked.
  task automatic model(input int k);
    exp_t e;
    int   idx;
    int   ny;
    bit   take;
    e.ack  = 1'b0;
    e.drop = 1'b0;
    if (rst[k] || clear[k]) begin
      for (int i = 0; i < SLOTS; i++) begin
        m_act[k][i] = 0; m_x[k][i] = 0; m_y[k][i] = 0;
      end
      m_cd[k] = 0;
    end else begin
      idx = -1;
      for (int i = SLOTS - 1; i >= 0; i--) if (m_act[k][i] == 0) idx = i;
      take = fire[k] && (m_cd[k] == 0) && (idx >= 0);
      for (int i = 0; i < SLOTS; i++) begin
        if (m_act[k][i] != 0) begin
          if (hit[k][i]) begin
            m_act[k][i] = 0;
          end else if (frame[k]) begin
            ny = (dir_up[k] != 0) ? m_y[k][i] - SPEED : m_y[k][i] + SPEED;
            if (ny < Y_MIN || ny > Y_MAX) m_act[k][i] = 0;
            else                          m_y[k][i]   = ny;
          end
        end
      end
      if (take) begin
        m_act[k][idx] = 1;
        m_x[k][idx]   = int'(fx[k]);
        m_y[k][idx]   = int'(fy[k]);
        m_cd[k]       = cd_len[k];
      end else if (frame[k] && m_cd[k] > 0) begin
        m_cd[k] = m_cd[k] - 1;
      end
      e.ack  = take;
      e.drop = fire[k] && !take;
    end
    e.cnt = '0;
    for (int i = 0; i < SLOTS; i++) begin
      e.act[i]          = (m_act[k][i] != 0);
      e.px[i*XW +: XW]  = XW'(m_x[k][i]);
      e.py[i*YW +: YW]  = YW'(m_y[k][i]);
      e.cnt             = e.cnt + 3'(m_act[k][i] != 0);
    end
    sb.push_back(e);
  endtask

  // Queue expectations, clock once, then compare both instances.
  task automatic tick();
    exp_t  e;
    string t;
    model(0);
    model(1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      t = $sformatf("u%0d", k);
      check({t, " ack"},  64'(ack[k]),  64'(e.ack));
      check({t, " drop"}, 64'(drop[k]), 64'(e.drop));
      check({t, " act"},  64'(act[k]),  64'(e.act));
      check({t, " px"},   64'(px[k]),   64'(e.px));
      check({t, " py"},   64'(py[k]),   64'(e.py));
      check({t, " cnt"},  64'(cnt[k]),  64'(e.cnt));
      fire[k]  = 1'b0;
      frame[k] = 1'b0;
      clear[k] = 1'b0;
      hit[k]   = '0;
    end
  endtask

  task automatic shoot(input int k, input int x, input int y);
    fire[k] = 1'b1;
    fx[k]   = XW'(x);
    fy[k]   = YW'(y);
  endtask

  function automatic logic [YW-1:0] ypos(input int k, input int s);
    return py[k][s*YW +: YW];
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; clear[k] = 1'b0; frame[k] = 1'b0; fire[k] = 1'b0;
      fx[k] = '0; fy[k] = '0; hit[k] = '0;
    end
    tick();
    tick();
    check("reset act", 64'(act[0]), 64'd0);
    check("reset ack", 64'(ack[0]), 64'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    // First shot and three frame steps upward.
    shoot(0, 100, 440);
    tick();
    check("first ack", 64'(ack[0]), 64'd1);
    check("first act", 64'(act[0]), 64'b0001);
    check("first y",   64'(ypos(0, 0)), 64'd440);
    repeat (3) begin frame[0] = 1'b1; tick(); end
    check("three frames y", 64'(ypos(0, 0)), 64'd428);
    check("three frames x", 64'(px[0][XW-1:0]), 64'd100);

    // Reset in flight with three live slots.
    shoot(0, 200, 400); tick();
    shoot(0, 300, 380); tick();
    frame[0] = 1'b1; tick();
    check("three live", 64'(cnt[0]), 64'd3);
    rst[0] = 1'b1;
    tick();
    check("midflight rst act", 64'(act[0]), 64'd0);
    check("midflight rst px",  64'(px[0]),  64'd0);
    check("midflight rst py",  64'(py[0]),  64'd0);
    rst[0] = 1'b0;
    tick();

    // Fill the pool, then overflow it.
    for (int n = 0; n < 5; n++) begin
      shoot(0, 50 + n * 10, 400);
      tick();
      if (n < 4) check("fill ack", 64'(ack[0]), 64'd1);
      else       check("full drop", 64'(drop[0]), 64'd1);
    end
    check("full cnt", 64'(cnt[0]), 64'd4);

    // Hit beats frame step on slot 1; the rest move.
    hit[0] = 4'b0010; frame[0] = 1'b1;
    tick();
    check("hit act",      64'(act[0]), 64'b1101);
    check("hit slot1 y",  64'(ypos(0, 1)), 64'd400);
    check("step slot0 y", 64'(ypos(0, 0)), 64'd396);

    // Refill slot 1; a slot freed by hit is not reusable in the same cycle.
    shoot(0, 60, 350); tick();
    check("refill ack", 64'(ack[0]), 64'd1);
    hit[0] = 4'b0100; shoot(0, 77, 300);
    tick();
    check("same cycle drop", 64'(drop[0]), 64'd1);
    check("same cycle act",  64'(act[0]), 64'b1011);
    shoot(0, 77, 300); tick();
    check("next cycle ack", 64'(ack[0]), 64'd1);
    check("next cycle act", 64'(act[0]), 64'b1111);

    // Synchronous clear, then fire together with frame.
    clear[0] = 1'b1; tick();
    check("clear act", 64'(act[0]), 64'd0);
    shoot(0, 10, 300); frame[0] = 1'b1; tick();
    check("fire+frame y", 64'(ypos(0, 0)), 64'd300);
    frame[0] = 1'b1; tick();
    check("fire+frame step", 64'(ypos(0, 0)), 64'd296);

    // Upward retire on underflow, and the top bound itself is on-screen.
    shoot(0, 20, 2); tick();
    frame[0] = 1'b1; tick();
    check("underflow retire", 64'(act[0]), 64'b0001);
    shoot(0, 20, 4); tick();
    frame[0] = 1'b1; tick();
    check("y_min live", 64'(act[0][1]), 64'd1);
    check("y_min y",    64'(ypos(0, 1)), 64'd0);
    frame[0] = 1'b1; tick();
    check("y_min retire", 64'(act[0][1]), 64'd0);

    // Cooldown of two frames on the downward instance.
    shoot(1, 10, 100); tick();
    check("cd first ack", 64'(ack[1]), 64'd1);
    frame[1] = 1'b1; tick();
    shoot(1, 11, 200); tick();
    check("cd drop", 64'(drop[1]), 64'd1);
    frame[1] = 1'b1; tick();
    shoot(1, 12, 200); tick();
    check("cd ack",     64'(ack[1]), 64'd1);
    check("cd act",     64'(act[1]), 64'b0011);
    check("cd slot1 y", 64'(ypos(1, 1)), 64'd200);

    // Downward bottom bound: 479 stays, anything past it retires.
    frame[1] = 1'b1; tick();
    frame[1] = 1'b1; tick();
    shoot(1, 13, 475); tick();
    frame[1] = 1'b1; tick();
    check("y_max live", 64'(act[1][2]), 64'd1);
    check("y_max y",    64'(ypos(1, 2)), 64'd479);
    frame[1] = 1'b1; tick();
    check("y_max retire", 64'(act[1][2]), 64'd0);
    shoot(1, 14, 478); tick();
    check("y478 ack", 64'(ack[1]), 64'd1);
    frame[1] = 1'b1; tick();
    check("y478 retire", 64'(act[1][2]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
